traffic_phase_scheduler: RTL
============================

Name: traffic_phase_scheduler

Overview:
- Sequences the four approach light boards (Back, Left, Front, Right = index 0..3) through green → amber → all-red phases.
- Decides which approach gets the next green: emergency requests first, then load (density) requests in round-robin order, otherwise plain rotation.
- Replaces free-running board rotation with a tick-driven, preemptible scheduler. Drives per-approach green/amber enables and a countdown value for the 7-segment display.

Parameters:
- GREEN_TICKS, 8, green duration in ticks (2..15)
- AMBER_TICKS, 3, amber duration in ticks (1..15)
- CLEAR_TICKS, 2, all-red clearance duration in ticks (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; clock clk
- tick  in  1  one-cycle timebase strobe; all phase timing counts ticks
- emerg_req  in  4  per-approach emergency request, level-sensitive
- load_req  in  4  per-approach heavy-load request, level-sensitive
- green  out  4  one-hot green enable, registered
- amber  out  4  one-hot amber enable, registered
- all_red  out  1  high during clearance phase, registered
- preempt  out  1  one-cycle pulse when a green is cut short by emergency
- countdown  out  4  remaining ticks in the current phase, registered
- cur_app  out  2  approach currently served (or last served, during all-red)

Behaviour:
- FSM states: S_GREEN, S_AMBER, S_CLEAR. A 4-bit down-counter cnt holds the remaining ticks minus one. countdown = cnt + 1.
- Reset: state = S_CLEAR; cnt = CLEAR_TICKS-1; cur_app = 3; green = 0; amber = 0; all_red = 1; preempt = 0. Reset mid-phase has the same effect on the next clk edge.
- Counting: cnt decrements only on cycles where tick = 1. A phase ends on a cycle where tick = 1 and cnt = 0.
- S_CLEAR end:
  - Compute next approach: if emerg_req != 0, the lowest set index; else if load_req != 0, the first set bit scanning cur_app+1, cur_app+2, … cyclically (cur_app itself is checked last); else cur_app+1 mod 4.
  - Load cur_app with the result, cnt = GREEN_TICKS-1, go to S_GREEN.
- S_GREEN end: cnt = AMBER_TICKS-1, go to S_AMBER.
- S_GREEN preemption: if emerg_req has any bit set other than cur_app, go to S_AMBER on the next clk edge regardless of tick or cnt. Load cnt = AMBER_TICKS-1 and pulse preempt for one cycle.
- S_GREEN extension: while emerg_req[cur_app] = 1 and no other emergency bit is set, hold cnt at GREEN_TICKS-1 (green never expires). load_req never extends green.
- Simultaneous emergency on cur_app and on another approach: preemption wins.
- S_AMBER end: cnt = CLEAR_TICKS-1, go to S_CLEAR. Amber is never shortened; emergency requests arriving during amber or clear affect only the next selection.
- Outputs are registered from the next-state values, so they change in the same edge as the state:
  - green = onehot(cur_app) only in S_GREEN.
  - amber = onehot(cur_app) only in S_AMBER.
  - all_red = 1 only in S_CLEAR.
  - Exactly one of {green != 0, amber != 0, all_red} is true every cycle.
- Requests are sampled, not latched. A request that drops before the selection point is ignored.

Decomposition:
- Shared package traffic_pkg holds:
  - state enum {S_GREEN, S_AMBER, S_CLEAR}
  - approach index constants APP_B = 0, APP_L = 1, APP_F = 2, APP_R = 3
  - NUM_APP = 4
- One sub-module, rr_pick: a combinational rotating-priority picker. Inputs are req[3:0] and a 2-bit start index. Outputs are a 2-bit index and a valid flag. It is used for the load_req scan. Emergency uses fixed lowest-index priority inline.

Test Plan:
- No requests, defaults, tick every cycle → after reset: 2 cycles all_red, then green = 0001 for 8 cycles, amber = 0001 for 3, all_red for 2, then green = 0010; the sequence wraps 0→1→2→3→0.
- load_req = 1000 held from reset → first green goes to approach 3. Then, with load_req = 1001 after the first cycle, greens alternate 0,3,0,3 (approaches 1 and 2 skipped).
- In S_GREEN on approach 0 with cnt = 5, assert emerg_req = 0100 → next edge amber = 0001, preempt = 1 for one cycle; after amber and clear, green = 0100.
- emerg_req = 0001 held during approach 0 green for 20 ticks → green stays 0001, countdown stays 8; release → green ends 8 ticks later.
- tick asserted only every 4th cycle → each phase lasts 4× the tick count in cycles; countdown decrements only on tick cycles.
- reset asserted mid-amber → next edge all_red = 1, amber = 0, cur_app = 3, countdown = 2; the next green is approach 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase scheduler.
// Holds the phase state enum, approach index constants and common widths.
package traffic_pkg;

  localparam int unsigned NUM_APP = 4;
  localparam int unsigned APP_W   = 2;
  localparam int unsigned CNT_W   = 4;

  localparam logic [APP_W-1:0] APP_B = 2'd0;
  localparam logic [APP_W-1:0] APP_L = 2'd1;
  localparam logic [APP_W-1:0] APP_F = 2'd2;
  localparam logic [APP_W-1:0] APP_R = 2'd3;

  typedef enum logic [1:0] {
    S_GREEN = 2'd0,
    S_AMBER = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  // One-hot enable vector for an approach index.
  function automatic logic [NUM_APP-1:0] app_onehot(input logic [APP_W-1:0] app);
    app_onehot = NUM_APP'(1) << app;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Ports: req_i (request vector), start_i (first index to scan),
//        idx_o (first set index scanning start_i, start_i+1, ... cyclically),
//        valid_o (any request set).
module rr_pick
  import traffic_pkg::*;
(
  input  logic [NUM_APP-1:0] req_i,
  input  logic [APP_W-1:0]   start_i,
  output logic [APP_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [APP_W-1:0] pos;

  // Scan from the farthest offset down so the nearest offset wins.
  always_comb begin
    idx_o   = start_i;
    valid_o = |req_i;
    pos     = start_i;
    for (int k = NUM_APP - 1; k >= 0; k--) begin
      pos = start_i + APP_W'(k);
      if (req_i[pos]) idx_o = pos;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: tick-driven, preemptible green/amber/all-red
// sequencer for four approaches (Back, Left, Front, Right = 0..3).
// Ports: clk, reset (sync, active-high), tick (timebase strobe),
//        emerg_req/load_req (level requests per approach),
//        green/amber (one-hot enables), all_red, preempt (1-cycle pulse),
//        countdown (remaining ticks in phase), cur_app (served approach).
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS = 8,
  parameter int unsigned AMBER_TICKS = 3,
  parameter int unsigned CLEAR_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NUM_APP-1:0] emerg_req,
  input  logic [NUM_APP-1:0] load_req,
  output logic [NUM_APP-1:0] green,
  output logic [NUM_APP-1:0] amber,
  output logic               all_red,
  output logic               preempt,
  output logic [CNT_W-1:0]   countdown,
  output logic [APP_W-1:0]   cur_app
);

  localparam logic [CNT_W-1:0] GREEN_LD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] AMBER_LD = CNT_W'(AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_TICKS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [APP_W-1:0]   cur_app_q, cur_app_d;
  logic [NUM_APP-1:0] green_q, green_d;
  logic [NUM_APP-1:0] amber_q, amber_d;
  logic               all_red_q, all_red_d;
  logic               preempt_q, preempt_d;
  logic [CNT_W-1:0]   countdown_q, countdown_d;

  logic [APP_W-1:0]   load_idx;
  logic               load_vld;
  logic [APP_W-1:0]   emerg_idx;
  logic [APP_W-1:0]   next_app;
  logic [NUM_APP-1:0] emerg_other;
  logic               phase_end;

  rr_pick u_rr_pick (
    .req_i   (load_req),
    .start_i (cur_app_q + APP_W'(1)),
    .idx_o   (load_idx),
    .valid_o (load_vld)
  );

  // Fixed lowest-index priority for emergency requests.
  always_comb begin
    emerg_idx = APP_B;
    for (int k = NUM_APP - 1; k >= 0; k--) begin
      if (emerg_req[k]) emerg_idx = APP_W'(k);
    end
  end

  always_comb begin
    if (|emerg_req)    next_app = emerg_idx;
    else if (load_vld) next_app = load_idx;
    else               next_app = cur_app_q + APP_W'(1);
  end

  assign emerg_other = emerg_req & ~app_onehot(cur_app_q);
  assign phase_end   = tick && (cnt_q == '0);

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_app_d = cur_app_q;
    preempt_d = 1'b0;

    unique case (state_q)
      S_GREEN: begin
        if (|emerg_other) begin
          state_d   = S_AMBER;
          cnt_d     = AMBER_LD;
          preempt_d = 1'b1;
        end else if (emerg_req[cur_app_q]) begin
          cnt_d = GREEN_LD;
        end else if (phase_end) begin
          state_d = S_AMBER;
          cnt_d   = AMBER_LD;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_AMBER: begin
        if (phase_end) begin
          state_d = S_CLEAR;
          cnt_d   = CLEAR_LD;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CLEAR: begin
        if (phase_end) begin
          state_d   = S_GREEN;
          cnt_d     = GREEN_LD;
          cur_app_d = next_app;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = CLEAR_LD;
      end
    endcase

    if (reset) begin
      state_d   = S_CLEAR;
      cnt_d     = CLEAR_LD;
      cur_app_d = APP_R;
      preempt_d = 1'b0;
    end

    green_d     = (state_d == S_GREEN) ? app_onehot(cur_app_d) : '0;
    amber_d     = (state_d == S_AMBER) ? app_onehot(cur_app_d) : '0;
    all_red_d   = (state_d == S_CLEAR);
    countdown_d = cnt_d + CNT_W'(1);
  end

  // Reset is folded into the next-state logic, so every register loads *_d.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    cur_app_q   <= cur_app_d;
    green_q     <= green_d;
    amber_q     <= amber_d;
    all_red_q   <= all_red_d;
    preempt_q   <= preempt_d;
    countdown_q <= countdown_d;
  end

  assign green     = green_q;
  assign amber     = amber_q;
  assign all_red   = all_red_q;
  assign preempt   = preempt_q;
  assign countdown = countdown_q;
  assign cur_app   = cur_app_q;

endmodule
